// File: rtl/canny_pkg.sv
// Shared types for the Canny edge pipeline: pixel class, hysteresis FSM states and
// the full-scale edge value helper.
package canny_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        WEAK   = 2'd1,
        STRONG = 2'd2
    } pix_class_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Full-scale output value (2^data_w - 1) for an edge pixel.
    function automatic logic [31:0] edge_max(input int unsigned data_w);
        return (32'd1 << data_w) - 32'd1;
    endfunction

endpackage

// File: rtl/hysteresis_threshold_if.sv
// Pixel stream bundle for the hysteresis stage: magnitudes in, binary edge map out.
// slave is the hysteresis block; master is whoever feeds and drains it.
interface hysteresis_threshold_if #(
    parameter int DATA_W = 8
) ();
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/hysteresis_window.sv
// Class delay line (2*WIDTH+3 taps, tap 0 = incoming class) exposing the centre and
// eight border-masked neighbours; shifts on demand, no latency beyond the shift itself.
module hysteresis_window
    import canny_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      shift,
    input  pix_class_t                din,
    input  logic [$clog2(HEIGHT)-1:0] row,
    input  logic [$clog2(WIDTH)-1:0]  col,
    output pix_class_t                centre,
    output pix_class_t                nbr [8]
);
    localparam int LINE = 2 * WIDTH + 2;
    localparam logic [$clog2(HEIGHT)-1:0] ROW_LAST = ($clog2(HEIGHT))'(HEIGHT - 1);
    localparam logic [$clog2(WIDTH)-1:0]  COL_LAST = ($clog2(WIDTH))'(WIDTH - 1);

    // line[i] is tap i+1; the incoming class is tap 0, so the window already
    // includes the pixel being accepted on this edge.
    pix_class_t line [LINE];

    logic top, bottom, left, right;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < LINE; i++) line[i] <= NONE;
        end else if (shift) begin
            line[0] <= din;
            for (int i = 1; i < LINE; i++) line[i] <= line[i-1];
        end
    end

    always_comb begin
        top    = (row == '0);
        bottom = (row == ROW_LAST);
        left   = (col == '0);
        right  = (col == COL_LAST);

        centre = line[WIDTH];
        nbr[0] = (bottom || right) ? NONE : din;
        nbr[1] = bottom            ? NONE : line[0];
        nbr[2] = (bottom || left)  ? NONE : line[1];
        nbr[3] = right             ? NONE : line[WIDTH-1];
        nbr[4] = left              ? NONE : line[WIDTH+1];
        nbr[5] = (top || right)    ? NONE : line[2*WIDTH-1];
        nbr[6] = top               ? NONE : line[2*WIDTH];
        nbr[7] = (top || left)     ? NONE : line[2*WIDTH+1];
    end

endmodule

// File: rtl/hysteresis_threshold.sv
// Double-threshold classification plus single-pass 8-neighbour hysteresis, raster in/out.
// Output k appears WIDTH+1 inputs after input k; one-entry output register, stalls input when full.
module hysteresis_threshold
    import canny_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DATA_W-1:0]    low_thresh,
    input  logic [DATA_W-1:0]    high_thresh,
    hysteresis_threshold_if.slave bus,
    output logic                 busy,
    output logic                 done
);
    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int COL_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(NPIX - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [DATA_W-1:0] EDGE_MAX  = DATA_W'(edge_max(DATA_W));

    state_t            state, state_nxt;
    logic [DATA_W-1:0] low_q, high_q;
    logic [CNT_W-1:0]  in_cnt;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              out_vld, out_last;
    logic [DATA_W-1:0] out_dat;

    logic       slot_free, s_rdy, accept, load, shift, clear, last_hs;
    logic       nbr_strong, promote;
    pix_class_t din_cls, centre;
    pix_class_t nbr [8];

    always_comb begin
        din_cls = NONE;
        if (state != FLUSH) begin
            if (bus.s_data >= high_q)     din_cls = STRONG;
            else if (bus.s_data >= low_q) din_cls = WEAK;
        end
    end

    always_comb begin
        state_nxt = state;
        slot_free = !out_vld || bus.m_ready;
        s_rdy     = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        clear     = 1'b0;
        last_hs   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = FILL;
                    clear     = 1'b1;
                end
            end
            FILL: begin
                s_rdy  = slot_free;
                accept = s_rdy && bus.s_valid;
                shift  = accept;
                if (accept && in_cnt == FILL_LAST) state_nxt = RUN;
            end
            RUN: begin
                s_rdy  = slot_free;
                accept = s_rdy && bus.s_valid;
                shift  = accept;
                load   = accept;
                if (accept && in_cnt == PIX_LAST) state_nxt = FLUSH;
            end
            FLUSH: begin
                // Once the frame's last output is registered, only its handshake matters.
                last_hs = out_vld && out_last && bus.m_ready;
                load    = slot_free && !(out_vld && out_last);
                shift   = load;
                if (last_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    hysteresis_window #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_window (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .shift  (shift),
        .din    (din_cls),
        .row    (row),
        .col    (col),
        .centre (centre),
        .nbr    (nbr)
    );

    always_comb begin
        nbr_strong = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (nbr[i] == STRONG) nbr_strong = 1'b1;
        end
        promote = (centre == STRONG) || (centre == WEAK && nbr_strong);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            low_q    <= '0;
            high_q   <= '0;
            in_cnt   <= '0;
            row      <= '0;
            col      <= '0;
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= last_hs;
            if (clear) begin
                low_q  <= low_thresh;
                high_q <= high_thresh;
                in_cnt <= '0;
                row    <= '0;
                col    <= '0;
            end
            if (accept) in_cnt <= in_cnt + 1'b1;
            if (load) begin
                out_vld  <= 1'b1;
                out_dat  <= promote ? EDGE_MAX : '0;
                out_last <= (row == ROW_LAST) && (col == COL_LAST);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else if (bus.m_ready) begin
                out_vld  <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end

    assign bus.s_ready = s_rdy;
    assign bus.m_valid = out_vld;
    assign bus.m_data  = out_dat;
    assign bus.m_last  = out_last;
    assign busy        = (state != IDLE);

endmodule

// File: doc/hysteresis_threshold.md
# hysteresis_threshold

Streams the thinned gradient magnitudes produced by non-maximum suppression, in raster order, and emits the final binary edge map (0 or 255 per pixel) for the Canny edge-detection pipeline. Each pixel is classified against two thresholds. A single-pass 8-neighbour hysteresis then promotes weak pixels that touch a strong pixel. The block sits directly downstream of non_max_suppression and buffers two image rows plus three pixels of class information.

## Interface
- WIDTH, 5: image width in pixels (≥2)
- HEIGHT, 5: image height in pixels (≥2)
- DATA_W, 8: magnitude bit width (unsigned)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  frame start pulse; honoured only in IDLE
- low_thresh  in  DATA_W  weak threshold; latched when enable is accepted
- high_thresh  in  DATA_W  strong threshold; latched when enable is accepted
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  DATA_W  input magnitude
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts on m_valid && m_ready
- m_data  out  DATA_W  0 or 2^DATA_W−1
- m_last  out  1  high with the final pixel of the frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, the cycle after the final output handshake

## Operation
- Classification, unsigned: s_data ≥ high → STRONG; else s_data ≥ low → WEAK; else NONE. If low > high, no pixel is WEAK.
- Delay line: 2·WIDTH+3 two-bit class entries. Index 0 holds the newest entry.
  - Centre pixel (r,c) sits at index WIDTH+1.
  - Neighbours sit at indices 0, 1, 2, WIDTH, WIDTH+2, 2·WIDTH, 2·WIDTH+1, 2·WIDTH+2.
- Border masking: neighbours outside the image are masked to NONE using the centre row/col counters. This covers the row −1 and row HEIGHT neighbours and the raster wrap between column WIDTH−1 and column 0.
- Output rule:
  - STRONG → max value.
  - WEAK with any unmasked STRONG neighbour → max value.
  - Otherwise → 0.
  - Promotion is single-pass; a promoted WEAK pixel does not itself promote other pixels.
- FSM:
  - IDLE: s_ready=0. On enable → FILL. Entering FILL clears the delay line to NONE, latches the thresholds and zeroes the counters.
  - FILL: accepts the first WIDTH+1 pixels and shifts them in; produces no output. Then → RUN.
  - RUN: each accepted pixel shifts in and loads one output. The pixel count reaches WIDTH·HEIGHT → FLUSH.
  - FLUSH: s_ready=0. Shifts in NONE and loads one output per free output slot, WIDTH+1 times. The last output carries m_last. On its handshake → IDLE, and done pulses next cycle.
- enable outside IDLE is ignored. Input after the final pixel is not accepted.
- rst at any time:
  - state → IDLE; counters and delay line cleared.
  - Output register: m_valid=0, m_data=0, m_last=0.
  - busy=0, done=0, s_ready=0.
  - The partial frame is discarded.

## Timing
- Output register is one entry. Output slot free = !m_valid || m_ready.
- s_ready = (FILL || RUN) && slot free. This is combinational from state, m_valid and m_ready.
- Output k (raster order) is loaded on the clock edge that accepts input k+WIDTH+1. m_valid rises the next cycle.
- In FLUSH, an output is loaded on every edge where the slot is free.
- With m_ready held 1 and s_valid held 1, throughput is one pixel per clock. Frame time from enable is WIDTH·HEIGHT+WIDTH+2 cycles to the last handshake.
- m_data, m_valid and m_last remain stable while m_valid && !m_ready.
- Counters:
  - Input count: $clog2(WIDTH·HEIGHT+1) bits.
  - Centre row/col: $clog2(HEIGHT) and $clog2(WIDTH) bits.

## Structure
- Package canny_pkg:
  - typedef enum {NONE, WEAK, STRONG} for the pixel class.
  - FSM state enum {IDLE, FILL, RUN, FLUSH}.
  - Constant EDGE_MAX = 2^DATA_W−1, expressed as a function of DATA_W.
- One sub-module, hysteresis_window. It holds the class delay line, shift enable and clear, and exposes centre plus eight masked neighbours given the centre row/col.
- FSM, counters, classification and the output register stay in the top.

## Test plan
- 5×5 input, low=50, high=200, m_ready=1. Input is the diamond: 255 at (2,2); 100 at (1,1),(1,2),(1,3),(2,1),(2,3),(3,1),(3,2),(3,3); 0 elsewhere. Expect 255 at all nine pixels; 0 elsewhere; m_last on output 24; done one cycle later.
- Threshold edges, low=50, high=200: 200 alone → 255; 199 beside 200 → 255; 49 beside 200 → 0; isolated 100 → 0.
- Raster-wrap masking: 100 at (0,4), 250 at (1,0), rest 0. Expect (0,4)=0 and (1,0)=255. Also 100 at (4,4) with 250 at (0,0) of the next frame → 0.
- Backpressure: the diamond frame with m_ready toggling 1,0,0,1 and s_valid random. Expect an identical output sequence, m_data stable while stalled, and no dropped or duplicated pixels (25 outputs).
- Reset mid-frame: rst for one cycle after 12 inputs. Expect m_valid=0, busy=0, s_ready=0. A fresh enable then processes a full frame correctly.
- enable pulsed during RUN with different thresholds: ignored; the frame uses the original thresholds.
